// File: rtl/fnd_pkg.sv
// Shared constants for the multiplexed 7-segment display controller.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}; dp is off in every constant.
package fnd_pkg;

    localparam int unsigned DIGITS    = 4;
    localparam int unsigned VAL_W     = 7;
    localparam int unsigned BCD_W     = 4;
    localparam int unsigned IDX_W     = 2;

    localparam logic [DIGITS-1:0] COMM_OFF = 4'b1111;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Decimal digit to segment pattern (without dp); codes 10..15 render as a dash.
    function automatic logic [6:0] digit_seg(input logic [BCD_W-1:0] d);
        logic [7:0] code;
        case (d)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_DASH;
        endcase
        return code[6:0];
    endfunction

endpackage

// File: rtl/fnd_bcd_seg.sv
// Splits a 0..99 value into tens/ones by compare-and-subtract and returns the
// selected digit's segment pattern; values above 99 show a dash.
module fnd_bcd_seg (
    input  logic [6:0] value,
    input  logic       tens_sel,
    output logic [6:0] seg
);
    import fnd_pkg::*;

    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;

    // Highest decade threshold not exceeding the value wins.
    always_comb begin
        tens = '0;
        ones = BCD_W'(value);
        seg  = SEG_DASH[6:0];
        for (int unsigned k = 1; k <= 9; k++) begin
            if (value >= VAL_W'(10 * k)) begin
                tens = BCD_W'(k);
                ones = BCD_W'(value - VAL_W'(10 * k));
            end
        end
        if (value <= 7'd99) begin
            seg = digit_seg(tens_sel ? tens : ones);
        end
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// 4-digit common-anode FND scanner with frame-boundary snapshot of the watch time.
// Optional FND_DOT_BLINK_EN: colon follows snapshot msec (< 50 lit), else steady.
module fnd_scan_ctrl #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned SCAN_HZ = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] msec,
    input  logic [6:0] sec,
    input  logic [6:0] min,
    input  logic [6:0] hour,
    input  logic       sel_mode,
    output logic [3:0] fnd_comm,
    output logic [7:0] fnd_font
);
    import fnd_pkg::*;

    localparam int unsigned DIV     = CLK_HZ / SCAN_HZ;
    localparam int unsigned CNT_W   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] prescale;
    logic [IDX_W-1:0] dig_idx;
    logic [VAL_W-1:0] snap_hour;
    logic [VAL_W-1:0] snap_min;
    logic [VAL_W-1:0] snap_sec;
    logic [VAL_W-1:0] snap_msec;
    logic             snap_mode;

    logic             scan_tick;
    logic             frame_start;
    logic [IDX_W-1:0] nxt_idx;
    logic [VAL_W-1:0] nxt_hour;
    logic [VAL_W-1:0] nxt_min;
    logic [VAL_W-1:0] nxt_sec;
    logic [VAL_W-1:0] nxt_msec;
    logic             nxt_mode;
    logic [VAL_W-1:0] hi_val;
    logic [VAL_W-1:0] lo_val;
    logic [VAL_W-1:0] dig_val;
    logic             tens_sel;
    logic [6:0]       seg;
    logic             dp_n;
    logic [DIGITS-1:0] comm_nxt;

    // Outputs are registered from the post-tick view (new index, new snapshot)
    // so the display changes exactly one cycle after scan_tick.
    always_comb begin
        scan_tick   = (prescale == CNT_MAX);
        frame_start = scan_tick && (dig_idx == IDX_W'(DIGITS - 1));
        nxt_idx     = dig_idx + IDX_W'(1);

        nxt_hour = snap_hour;
        nxt_min  = snap_min;
        nxt_sec  = snap_sec;
        nxt_msec = snap_msec;
        nxt_mode = snap_mode;
        if (frame_start) begin
            nxt_hour = hour;
            nxt_min  = min;
            nxt_sec  = sec;
            nxt_msec = msec;
            nxt_mode = sel_mode;
        end

        hi_val   = nxt_mode ? nxt_sec  : nxt_hour;
        lo_val   = nxt_mode ? nxt_msec : nxt_min;
        dig_val  = nxt_idx[1] ? hi_val : lo_val;
        tens_sel = nxt_idx[0];

`ifdef FND_DOT_BLINK_EN
        dp_n = (nxt_idx == 2'd2) ? (nxt_msec >= 7'd50) : 1'b1;
`else
        dp_n = (nxt_idx != 2'd2);
`endif

        comm_nxt          = COMM_OFF;
        comm_nxt[nxt_idx] = 1'b0;
    end

    fnd_bcd_seg u_bcd_seg (
        .value    (dig_val),
        .tens_sel (tens_sel),
        .seg      (seg)
    );

    // dig_idx resets to 3 so the first tick wraps to 0 and loads the snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale  <= '0;
            dig_idx   <= IDX_W'(DIGITS - 1);
            snap_hour <= '0;
            snap_min  <= '0;
            snap_sec  <= '0;
            snap_msec <= '0;
            snap_mode <= 1'b0;
            fnd_comm  <= COMM_OFF;
            fnd_font  <= SEG_BLANK;
        end else begin
            prescale <= scan_tick ? '0 : prescale + CNT_W'(1);
            if (scan_tick) begin
                dig_idx  <= nxt_idx;
                fnd_comm <= comm_nxt;
                fnd_font <= {dp_n, seg};
            end
            if (frame_start) begin
                snap_hour <= hour;
                snap_min  <= min;
                snap_sec  <= sec;
                snap_msec <= msec;
                snap_mode <= sel_mode;
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl at DIV=4: expected slots are queued when
// inputs are driven and checked slot by slot, including the hold across each slot.
module tb_fnd_scan_ctrl;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [6:0] msec     = '0;
    logic [6:0] sec      = '0;
    logic [6:0] min      = '0;
    logic [6:0] hour     = '0;
    logic       sel_mode = 1'b0;
    logic [3:0] fnd_comm;
    logic [7:0] fnd_font;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] exp_q[$];
    logic [11:0] prev_exp;
    logic [7:0]  seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    localparam logic [11:0] BLANK = 12'hFFF;

    always #5 clk = ~clk;

    fnd_scan_ctrl #(.CLK_HZ(40), .SCAN_HZ(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .msec     (msec),
        .sec      (sec),
        .min      (min),
        .hour     (hour),
        .sel_mode (sel_mode),
        .fnd_comm (fnd_comm),
        .fnd_font (fnd_font)
    );

    function automatic logic [7:0] font_of(input int v, input bit tens, input bit dp_on);
        logic [7:0] f;
        if (v > 99) f = 8'hBF;
        else        f = seg_tbl[tens ? (v / 10) : (v % 10)];
        if (dp_on) f[7] = 1'b0;
        return f;
    endfunction

    function automatic bit colon_on(input int ms);
        bit on;
`ifdef FND_DOT_BLINK_EN
        on = (ms < 50);
`else
        on = (ms >= 0);
`endif
        return on;
    endfunction

    // Queue the four slots of one frame: digit 0 (right) first.
    task automatic push_frame(input int hi, input int lo, input int ms);
        logic [3:0] c;
        logic [7:0] f;
        for (int i = 0; i < 4; i++) begin
            c    = 4'b1111;
            c[i] = 1'b0;
            case (i)
                0:       f = font_of(lo, 1'b0, 1'b0);
                1:       f = font_of(lo, 1'b1, 1'b0);
                2:       f = font_of(hi, 1'b0, colon_on(ms));
                default: f = font_of(hi, 1'b1, 1'b0);
            endcase
            exp_q.push_back({c, f});
        end
    endtask

    // Samples the last cycle of the current slot, then the first cycle of the next.
    task automatic advance_slot(output logic [11:0] hold_obs, output logic [11:0] obs);
        repeat (3) @(posedge clk);
        #1 hold_obs = {fnd_comm, fnd_font};
        @(posedge clk);
        #1 obs = {fnd_comm, fnd_font};
    endtask

    task automatic test_reset();
        logic [11:0] h, o, e;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (fnd_comm !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_comm: got %b expected 1111", fnd_comm);
        end
        n_checks++;
        if (fnd_font !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_font: got %h expected ff", fnd_font);
        end
        @(negedge clk) reset = 1'b0;
        prev_exp = BLANK;
        push_frame(0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            advance_slot(h, o);
            e = exp_q.pop_front();
            n_checks++;
            if (h !== prev_exp) begin
                n_fail++;
                $display("FAIL reset_hold slot %0d: got %h expected %h", i, h, prev_exp);
            end
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_first_frame slot %0d: got %h expected %h", i, o, e);
            end
            prev_exp = e;
        end
    endtask

    task automatic test_mode0_scan();
        logic [11:0] h, o, e;
        hour = 7'd12; min = 7'd34; sel_mode = 1'b0;
        push_frame(12, 34, int'(msec));
        push_frame(12, 34, int'(msec));
        for (int i = 0; i < 8; i++) begin
            advance_slot(h, o);
            e = exp_q.pop_front();
            n_checks++;
            if (h !== prev_exp) begin
                n_fail++;
                $display("FAIL mode0_hold slot %0d: got %h expected %h", i, h, prev_exp);
            end
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL mode0_scan slot %0d: got %h expected %h", i, o, e);
            end
            prev_exp = e;
        end
    endtask

    task automatic test_mode_switch();
        logic [11:0] h, o, e;
        push_frame(12, 34, int'(msec));
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                sel_mode = 1'b1; sec = 7'd59; msec = 7'd7;
            end
            if (i == 3) push_frame(59, 7, 7);
            advance_slot(h, o);
            e = exp_q.pop_front();
            n_checks++;
            if (h !== prev_exp) begin
                n_fail++;
                $display("FAIL switch_hold slot %0d: got %h expected %h", i, h, prev_exp);
            end
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL mode_switch slot %0d: got %h expected %h", i, o, e);
            end
            prev_exp = e;
        end
    endtask

    task automatic test_tear_free();
        logic [11:0] h, o, e;
        sel_mode = 1'b0; hour = 7'd12; min = 7'd59;
        push_frame(12, 59, int'(msec));
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                min = 7'd0;
                push_frame(12, 0, int'(msec));
            end
            advance_slot(h, o);
            e = exp_q.pop_front();
            n_checks++;
            if (h !== prev_exp) begin
                n_fail++;
                $display("FAIL tear_hold slot %0d: got %h expected %h", i, h, prev_exp);
            end
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL tear_free slot %0d: got %h expected %h", i, o, e);
            end
            prev_exp = e;
        end
    endtask

    task automatic test_out_of_range();
        logic [11:0] h, o, e;
        int hv [3] = '{7, 23, 127};
        int mv [3] = '{100, 99, 0};
        for (int f = 0; f < 3; f++) begin
            hour = 7'(hv[f]); min = 7'(mv[f]);
            push_frame(hv[f], mv[f], int'(msec));
            for (int i = 0; i < 4; i++) begin
                advance_slot(h, o);
                e = exp_q.pop_front();
                n_checks++;
                if (h !== prev_exp) begin
                    n_fail++;
                    $display("FAIL range_hold frame %0d slot %0d: got %h expected %h", f, i, h, prev_exp);
                end
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL out_of_range frame %0d slot %0d: got %h expected %h", f, i, o, e);
                end
                prev_exp = e;
            end
        end
    endtask

    task automatic test_colon();
        logic [11:0] h, o, e;
        int ms [4] = '{49, 50, 49, 99};
        hour = 7'd8; min = 7'd15; sec = 7'd30;
        for (int f = 0; f < 4; f++) begin
            sel_mode = (f >= 2);
            msec = 7'(ms[f]);
            if (f >= 2) push_frame(30, ms[f], ms[f]);
            else        push_frame(8, 15, ms[f]);
            for (int i = 0; i < 4; i++) begin
                advance_slot(h, o);
                e = exp_q.pop_front();
                n_checks++;
                if (h !== prev_exp) begin
                    n_fail++;
                    $display("FAIL colon_hold frame %0d slot %0d: got %h expected %h", f, i, h, prev_exp);
                end
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL colon frame %0d slot %0d: got %h expected %h", f, i, o, e);
                end
                prev_exp = e;
            end
        end
    endtask

    task automatic test_random_frames();
        logic [11:0] h, o, e;
        for (int f = 0; f < 6; f++) begin
            sel_mode = 1'($urandom_range(0, 1));
            hour = 7'($urandom_range(0, 127));
            min  = 7'($urandom_range(0, 127));
            sec  = 7'($urandom_range(0, 127));
            msec = 7'($urandom_range(0, 127));
            if (sel_mode) push_frame(int'(sec), int'(msec), int'(msec));
            else          push_frame(int'(hour), int'(min), int'(msec));
            for (int i = 0; i < 4; i++) begin
                advance_slot(h, o);
                e = exp_q.pop_front();
                n_checks++;
                if (h !== prev_exp) begin
                    n_fail++;
                    $display("FAIL random_hold frame %0d slot %0d: got %h expected %h", f, i, h, prev_exp);
                end
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL random frame %0d slot %0d: got %h expected %h", f, i, o, e);
                end
                prev_exp = e;
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [11:0] h, o, e;
        sel_mode = 1'b0; hour = 7'd21; min = 7'd46; msec = 7'd10;
        push_frame(21, 46, 10);
        for (int i = 0; i < 2; i++) begin
            advance_slot(h, o);
            e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL pre_reset slot %0d: got %h expected %h", i, o, e);
            end
            prev_exp = e;
        end
        #3 reset = 1'b1;
        #1;
        n_checks++;
        if ({fnd_comm, fnd_font} !== BLANK) begin
            n_fail++;
            $display("FAIL async_reset_blank: got %h expected %h", {fnd_comm, fnd_font}, BLANK);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        prev_exp = BLANK;
        push_frame(21, 46, 10);
        for (int i = 0; i < 4; i++) begin
            advance_slot(h, o);
            e = exp_q.pop_front();
            n_checks++;
            if (h !== prev_exp) begin
                n_fail++;
                $display("FAIL restart_hold slot %0d: got %h expected %h", i, h, prev_exp);
            end
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL restart slot %0d: got %h expected %h", i, o, e);
            end
            prev_exp = e;
        end
    endtask

    initial begin
        test_reset();
        test_mode0_scan();
        test_mode_switch();
        test_tear_free();
        test_out_of_range();
        test_colon();
        test_random_frames();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fnd_scan_ctrl.md
# fnd_scan_ctrl

Consumer side of the watch time counters. It takes the four 7-bit time values from the watch datapath, splits each into two decimal digits, and drives a 4-digit, common-anode, multiplexed 7-segment (FND) display. Digits are scanned one at a time at a fixed refresh rate. Each 4-digit frame is snapshotted at its boundary, so a digit pair never tears mid-frame.

## Interface
- `CLK_HZ`, default 100_000_000: system clock frequency.
- `SCAN_HZ`, default 1000: digit-advance rate. `DIV = CLK_HZ/SCAN_HZ` must be ≥ 2.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `msec`  in  7  hundredths of a second, 0..99.
- `sec`  in  7  seconds, 0..59.
- `min`  in  7  minutes, 0..59.
- `hour`  in  7  hours, 0..23.
- `sel_mode`  in  1  0 = show hour:min; 1 = show sec:msec.
- `fnd_comm`  out  4  digit enables, active-low. Bit 0 is the rightmost digit.
- `fnd_font`  out  8  segments, active-low. Bit 7 = dp; bits 6..0 = g,f,e,d,c,b,a.

## Operation
- **Prescaler:** counts 0..DIV-1 and emits a 1-cycle `scan_tick` when the count is DIV-1, then wraps to 0.
- **Digit index:** 2-bit `dig_idx`, advances 0→1→2→3→0 on each `scan_tick`.
- **Frame snapshot:** on a `scan_tick` where `dig_idx` goes 3→0, and on the first `scan_tick` after reset, latch:
  - all four time inputs;
  - `sel_mode`.
  - A mode change therefore appears only at the next frame start.
- **Digit map**, from the snapshot:
  - mode 0: digit3 = hour tens, digit2 = hour ones, digit1 = min tens, digit0 = min ones.
  - mode 1: same layout using sec (digits 3,2) and msec (digits 1,0).
- **Split:** tens = v/10, ones = v%10, by compare/subtract. No divider IP.
- **Out-of-range value** (> 99): both digits of that pair show a dash, segment g only (`fnd_font[6:0]` = 7'h3F).
- **Segment codes** (`fnd_font` with dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99
  - 5=92, 6=82, 7=F8, 8=80, 9=90, dash=BF
- **Separator:** the dp of digit 2 is the colon. dp is off on all other digits.
- **Outputs:** `fnd_comm` is one-hot low (digit k → bit k = 0). Both outputs are registered.

## Timing
- **Reset values:**
  - `fnd_comm` = 4'b1111 (all digits off);
  - `fnd_font` = 8'hFF (blank);
  - prescaler = 0, `dig_idx` = 3, snapshot = 0, `sel_mode` snapshot = 0.
- **First scan tick:** occurs DIV cycles after reset release. The snapshot loads in that cycle, and digit 0 is displayed from the following cycle.
- **Latency:** `fnd_comm`/`fnd_font` change exactly 1 cycle after `scan_tick`. Both change in the same cycle, so there is no segment/common skew.
- **Hold:** each digit is held for exactly DIV cycles; a full frame is 4·DIV cycles.
- **Input sampling:** input changes between snapshots are ignored. An input changing in the snapshot cycle is captured with its pre-edge value.
- **Reset mid-frame:** all outputs blank immediately (asynchronous). Scanning restarts as described above.

## Configuration
- `FND_DOT_BLINK_EN`:
  - Defined: the digit-2 dp is lit when snapshot msec < 50 and dark otherwise. This gives a 1 Hz colon blink that follows the watch in both modes.
  - Undefined: the digit-2 dp is lit steadily, and no msec comparison logic is built.

## Structure
- **Package `fnd_pkg`:**
  - segment-code constants (`SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_BLANK`);
  - `DIGITS = 4`;
  - `COMM_OFF = 4'b1111`.
- **Sub-module `fnd_bcd_seg`:**
  - purely combinational;
  - input: 7-bit value plus a tens/ones select;
  - output: 7-bit segment code, dash for > 99.
  - Instantiate once, fed by a mux on `dig_idx`.

## Test plan
Use CLK_HZ=40, SCAN_HZ=10 (DIV=4) for all scenarios.

1. **Reset:** hold `reset` high → `fnd_comm`=1111, `fnd_font`=FF. Release → first change after 4 cycles: `fnd_comm`=1110 and `fnd_font`=C0 (hour=min=0 at snapshot).
2. **Mode 0 scan:** hour=12, min=34, sel_mode=0 → per 4-cycle slot, (`fnd_comm`, `fnd_font`) reads:
   - (1110, 99), (1101, B0), (1011, A4 & 7F = 24 dp on), (0111, F9);
   - repeating every 16 cycles.
3. **Mode switch mid-frame:** toggle sel_mode=1 with sec=59, msec=7 at digit 1 → the remainder of the frame still shows hour:min. From the next frame: digit0=F8, digit1=C0, digit2=90 & dp, digit3=92.
4. **Tear-free snapshot:** change min 59→00 while digit 1 is shown → digit 0 of the same frame still reflects the old value. The new value appears only after the 3→0 wrap.
5. **Out-of-range:** min=100 → digits 0 and 1 show BF. Hour digits are unaffected.
6. **Colon with `FND_DOT_BLINK_EN` defined:** msec=49 → digit2 `fnd_font` bit7=0. msec=50 → bit7=1. With the macro undefined, bit7=0 for both values.
